// File: rtl/noncoherent_sum_pkg.sv
// Shared tracking-engine definitions for the noncoherent sum stage and its
// neighbours: FSM state encoding, RAM address/data widths, I/Q field positions
// inside a coherent RAM word, and default tuning values.
package noncoherent_sum_pkg;

  localparam int ADDR_W          = 10;
  localparam int DATA_W          = 32;
  localparam int IQ_W            = 16;
  localparam int I_MSB           = 31;
  localparam int I_LSB           = 16;
  localparam int Q_MSB           = 15;
  localparam int Q_LSB           = 0;
  localparam int POWER_SHIFT_DEF = 8;
  localparam int MAX_COR_DEF     = 16;
  localparam int CNT_W           = 5;
  localparam int IDX_W           = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_COH = 3'd1,
    ST_READ_COH = 3'd2,
    ST_CALC     = 3'd3,
    ST_ACCUM    = 3'd4,
    ST_WRITE    = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

endpackage

// File: rtl/noncoherent_sum_if.sv
// Bus bundle for noncoherent_sum: request/control lines plus the coherent and
// noncoherent RAM ports. The slave modport is the block's view, the master
// modport is the view of whoever drives requests and models the RAMs.
// Optional macro NONCOH_PEAK_EN adds peak_power / peak_index outputs.
interface noncoherent_sum_if;
  import noncoherent_sum_pkg::*;

  logic                 noncoh_req;
  logic [ADDR_W-1:0]    coh_base_addr;
  logic [ADDR_W-1:0]    noncoh_base_addr;
  logic [CNT_W-1:0]     cor_count;
  logic                 first_noncoh;
  logic                 coherent_sum_done;
  logic                 busy;
  logic                 noncoh_done;
  logic                 coh_rd;
  logic [ADDR_W-1:0]    coh_addr;
  logic [DATA_W-1:0]    coherent_d4rd;
  logic                 noncoh_rd;
  logic                 noncoh_wr;
  logic [ADDR_W-1:0]    noncoh_addr;
  logic [DATA_W-1:0]    noncoh_d4wt;
  logic [DATA_W-1:0]    noncoh_d4rd;
`ifdef NONCOH_PEAK_EN
  logic [DATA_W-1:0]    peak_power;
  logic [IDX_W-1:0]     peak_index;
`endif

  modport slave (
    input  noncoh_req, coh_base_addr, noncoh_base_addr, cor_count, first_noncoh,
    input  coherent_sum_done, coherent_d4rd, noncoh_d4rd,
`ifdef NONCOH_PEAK_EN
    output peak_power, peak_index,
`endif
    output busy, noncoh_done, coh_rd, coh_addr, noncoh_rd, noncoh_wr,
    output noncoh_addr, noncoh_d4wt
  );

  modport master (
    output noncoh_req, coh_base_addr, noncoh_base_addr, cor_count, first_noncoh,
    output coherent_sum_done, coherent_d4rd, noncoh_d4rd,
`ifdef NONCOH_PEAK_EN
    input  peak_power, peak_index,
`endif
    input  busy, noncoh_done, coh_rd, coh_addr, noncoh_rd, noncoh_wr,
    input  noncoh_addr, noncoh_d4wt
  );

endinterface

// File: rtl/noncoherent_sum_iq_power.sv
// Combinational I/Q power: (I*I + Q*Q) >> POWER_SHIFT for one packed
// coherent word {I[31:16], Q[15:0]}, both signed. Shared with acquisition.
// Ports: i_iq (packed I/Q word), o_power (scaled power, unsigned).
module noncoherent_sum_iq_power
  import noncoherent_sum_pkg::*;
#(
  parameter int POWER_SHIFT = POWER_SHIFT_DEF
) (
  input  logic [DATA_W-1:0] i_iq,
  output logic [DATA_W-1:0] o_power
);

  logic signed [IQ_W-1:0]     w_i;
  logic signed [IQ_W-1:0]     w_q;
  logic signed [2*IQ_W-1:0]   w_ii;
  logic signed [2*IQ_W-1:0]   w_qq;
  logic        [DATA_W-1:0]   w_sum;

  assign w_i  = i_iq[I_MSB:I_LSB];
  assign w_q  = i_iq[Q_MSB:Q_LSB];
  assign w_ii = w_i * w_i;
  assign w_qq = w_q * w_q;
  // Each square is at most 2^30, so the unsigned sum peaks at 2^31 and
  // never overflows 32 bits.
  assign w_sum   = $unsigned(w_ii) + $unsigned(w_qq);
  assign o_power = w_sum >> POWER_SHIFT;

endmodule

// File: rtl/noncoherent_sum.sv
// Noncoherent sum stage: for each of up to MAX_COR entries, waits for the
// coherent stage to be drained, reads one coherent I/Q word, forms its power,
// optionally adds the stored noncoherent value (saturating) and writes it back.
// Ports: clk, rst_b (async, active low), bus (noncoherent_sum_if.slave).
// Optional macro NONCOH_PEAK_EN tracks the largest written result and its index.
module noncoherent_sum
  import noncoherent_sum_pkg::*;
#(
  parameter int POWER_SHIFT = POWER_SHIFT_DEF,
  parameter int MAX_COR     = MAX_COR_DEF
) (
  input  logic               clk,
  input  logic               rst_b,
  noncoherent_sum_if.slave   bus
);

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W] ? '1 : s[DATA_W-1:0];
  endfunction

  state_e              r_state;
  state_e              w_next;
  logic [IDX_W-1:0]    r_index;
  logic [IDX_W-1:0]    r_last;
  logic [ADDR_W-1:0]   r_coh_base;
  logic [ADDR_W-1:0]   r_noncoh_base;
  logic                r_first;
  logic [CNT_W-1:0]    w_count;
  logic [DATA_W-1:0]   w_power;
  logic [DATA_W-1:0]   r_power_p1;
  logic [DATA_W-1:0]   r_result_p2;
`ifdef NONCOH_PEAK_EN
  logic [DATA_W-1:0]   r_peak_power;
  logic [IDX_W-1:0]    r_peak_index;
`endif

  assign w_count = (bus.cor_count > CNT_W'(MAX_COR)) ? CNT_W'(MAX_COR) : bus.cor_count;

  noncoherent_sum_iq_power #(.POWER_SHIFT(POWER_SHIFT)) u_iq_power (
    .i_iq    (bus.coherent_d4rd),
    .o_power (w_power)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (bus.noncoh_req) w_next = (w_count == '0) ? ST_DONE : ST_WAIT_COH;
      ST_WAIT_COH: if (bus.coherent_sum_done) w_next = ST_READ_COH;
      ST_READ_COH: w_next = ST_CALC;
      ST_CALC:     w_next = ST_ACCUM;
      ST_ACCUM:    w_next = ST_WRITE;
      ST_WRITE:    w_next = (r_index == r_last) ? ST_DONE : ST_WAIT_COH;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state       <= ST_IDLE;
      r_index       <= '0;
      r_last        <= '0;
      r_coh_base    <= '0;
      r_noncoh_base <= '0;
      r_first       <= 1'b0;
`ifdef NONCOH_PEAK_EN
      r_peak_power  <= '0;
      r_peak_index  <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && bus.noncoh_req) begin
        r_coh_base    <= bus.coh_base_addr;
        r_noncoh_base <= bus.noncoh_base_addr;
        r_first       <= bus.first_noncoh;
        r_index       <= '0;
        // Count of zero never reaches WRITE, so the wrapped value is unused.
        r_last        <= IDX_W'(w_count - CNT_W'(1));
`ifdef NONCOH_PEAK_EN
        r_peak_power  <= '0;
        r_peak_index  <= '0;
`endif
      end
      if (r_state == ST_WRITE) begin
        if (r_index != r_last) r_index <= r_index + IDX_W'(1);
`ifdef NONCOH_PEAK_EN
        // Strict compare keeps the lowest index on ties.
        if (r_result_p2 > r_peak_power) begin
          r_peak_power <= r_result_p2;
          r_peak_index <= r_index;
        end
`endif
      end
    end
  end

  // Stage p1: coherent word is on the read bus, register its power.
  always_ff @(posedge clk) begin
    if (r_state == ST_CALC) r_power_p1 <= w_power;
  end

  // Stage p2: noncoherent word is on the read bus, form the accumulated result.
  always_ff @(posedge clk) begin
    if (r_state == ST_ACCUM)
      r_result_p2 <= r_first ? r_power_p1 : sat_add(bus.noncoh_d4rd, r_power_p1);
  end

  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.noncoh_done = (r_state == ST_DONE);
  assign bus.coh_rd      = (r_state == ST_READ_COH);
  assign bus.noncoh_rd   = (r_state == ST_CALC) && !r_first;
  assign bus.noncoh_wr   = (r_state == ST_WRITE);
  // Address sums wrap naturally at the 10-bit width.
  assign bus.coh_addr    = r_coh_base + ADDR_W'(r_index);
  assign bus.noncoh_addr = r_noncoh_base + ADDR_W'(r_index);
  // Write data is only driven in WRITE so it reads as zero while reset holds.
  assign bus.noncoh_d4wt = (r_state == ST_WRITE) ? r_result_p2 : '0;
`ifdef NONCOH_PEAK_EN
  assign bus.peak_power  = r_peak_power;
  assign bus.peak_index  = r_peak_index;
`endif

endmodule

// File: tb/tb_noncoherent_sum.sv
module tb_noncoherent_sum;
  logic clk;
  logic rst_b;
  int   n_checks;
  int   n_errors;

  noncoherent_sum_if bus_if();

  noncoherent_sum dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] coh_mem    [1024];
  logic [31:0] noncoh_mem [1024];
  logic [9:0]  wr_a_q [$];
  logic [31:0] wr_d_q [$];
  int crd_cnt, nrd_cnt, excl_viol, stall_viol, done_cnt;

  // RAM models: data appears the cycle after the read strobe; writes are logged.
  always @(posedge clk) begin
    if (bus_if.coh_rd)    bus_if.coherent_d4rd <= coh_mem[bus_if.coh_addr];
    if (bus_if.noncoh_rd) bus_if.noncoh_d4rd   <= noncoh_mem[bus_if.noncoh_addr];
    if (bus_if.noncoh_wr) begin
      wr_a_q.push_back(bus_if.noncoh_addr);
      wr_d_q.push_back(bus_if.noncoh_d4wt);
    end
    if (bus_if.coh_rd) crd_cnt++;
    if (bus_if.noncoh_rd) nrd_cnt++;
    if (bus_if.noncoh_done) done_cnt++;
    if ((32'(bus_if.coh_rd) + 32'(bus_if.noncoh_rd) + 32'(bus_if.noncoh_wr)) > 1) excl_viol++;
    if (bus_if.coh_rd && !bus_if.coherent_sum_done) stall_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Runs one request and compares against a model built from the entry rules.
  task automatic run_req(input string tag, input logic [9:0] cb, input logic [9:0] nb,
                         input logic [4:0] cnt, input logic first, input bit stall,
                         input bit dup_req);
    logic [9:0]  ea [$];
    logic [31:0] ed [$];
    logic [31:0] w, pk;
    logic [3:0]  pidx;
    longint p, r;
    int n, iv, qv, wb, crd0, nrd0, cyc, stall_left, exp_lat;
    bit got, stalled;
    n = (cnt > 16) ? 16 : int'(cnt);
    pk = 0; pidx = 0;
    for (int i = 0; i < n; i++) begin
      w  = coh_mem[10'(cb + 10'(i))];
      iv = int'($signed(w[31:16]));
      qv = int'($signed(w[15:0]));
      p  = (longint'(iv) * iv + longint'(qv) * qv) >>> 8;
      r  = first ? p : longint'(noncoh_mem[10'(nb + 10'(i))]) + p;
      if (r > 64'h0_FFFF_FFFF) r = 64'h0_FFFF_FFFF;
      ea.push_back(10'(nb + 10'(i)));
      ed.push_back(32'(r));
      if (32'(r) > pk) begin pk = 32'(r); pidx = 4'(i); end
    end
    exp_lat = (n == 0) ? 1 : 5 * n + 1 + (stall ? 5 : 0);
    wb = wr_a_q.size(); crd0 = crd_cnt; nrd0 = nrd_cnt;
    bus_if.coh_base_addr    = cb;
    bus_if.noncoh_base_addr = nb;
    bus_if.cor_count        = cnt;
    bus_if.first_noncoh     = first;
    bus_if.noncoh_req       = 1'b1;
    cyc = 0; got = 0; stalled = 0; stall_left = 0;
    while (cyc < 300 && !got) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        bus_if.noncoh_req = 1'b0;
        chk({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
      end
      if (dup_req && cyc == 3) begin
        bus_if.coh_base_addr    = cb + 10'd5;
        bus_if.noncoh_base_addr = nb + 10'd7;
        bus_if.cor_count        = 5'd1;
        bus_if.first_noncoh     = ~first;
        bus_if.noncoh_req       = 1'b1;
      end
      if (dup_req && cyc == 4) bus_if.noncoh_req = 1'b0;
      if (bus_if.noncoh_done) got = 1;
      if (stall && !stalled && (wr_a_q.size() - wb) == 1) begin
        bus_if.coherent_sum_done = 1'b0;
        stall_left = 5;
        stalled = 1;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) bus_if.coherent_sum_done = 1'b1;
      end
    end
    bus_if.coherent_sum_done = 1'b1;
    chk({tag, "_done"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(bus_if.noncoh_done), 32'd0);
    chk({tag, "_idle"}, 32'(bus_if.busy), 32'd0);
    chk({tag, "_nwr"}, 32'(wr_a_q.size() - wb), 32'(n));
    chk({tag, "_ncohrd"}, 32'(crd_cnt - crd0), 32'(n));
    chk({tag, "_nnrd"}, 32'(nrd_cnt - nrd0), first ? 32'd0 : 32'(n));
    for (int i = 0; i < n; i++) begin
      if (wb + i < wr_a_q.size()) begin
        chk($sformatf("%s_wa%0d", tag, i), 32'(wr_a_q[wb + i]), 32'(ea[i]));
        chk($sformatf("%s_wd%0d", tag, i), wr_d_q[wb + i], ed[i]);
      end
    end
`ifdef NONCOH_PEAK_EN
    chk({tag, "_peak_pw"}, bus_if.peak_power, pk);
    chk({tag, "_peak_ix"}, 32'(bus_if.peak_index), 32'(pidx));
`endif
  endtask

  logic [9:0] rcb, rnb;
  logic [4:0] rcnt;
  logic       rfirst;
  int         wbx, donex, cyc;

  initial begin
    n_checks = 0; n_errors = 0;
    crd_cnt = 0; nrd_cnt = 0; excl_viol = 0; stall_viol = 0; done_cnt = 0;
    for (int i = 0; i < 1024; i++) begin coh_mem[i] = '0; noncoh_mem[i] = '0; end
    bus_if.noncoh_req = 0; bus_if.coh_base_addr = '0; bus_if.noncoh_base_addr = '0;
    bus_if.cor_count = '0; bus_if.first_noncoh = 0; bus_if.coherent_sum_done = 1;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_done", 32'(bus_if.noncoh_done), 32'd0);
    chk("rst_strobes", {29'd0, bus_if.coh_rd, bus_if.noncoh_rd, bus_if.noncoh_wr}, 32'd0);
    chk("rst_coh_addr", 32'(bus_if.coh_addr), 32'd0);
    chk("rst_noncoh_addr", 32'(bus_if.noncoh_addr), 32'd0);
    chk("rst_d4wt", bus_if.noncoh_d4wt, 32'd0);
    rst_b = 1'b1;
    @(posedge clk); #1;

    // Overwrite mode, two entries.
    coh_mem[10] = 32'h0100_0000; coh_mem[11] = 32'hFF00_0100;
    run_req("ovr", 10'd10, 10'd50, 5'd2, 1'b1, 0, 0);
    chk("ovr_const0", wr_d_q[wr_d_q.size() - 2], 32'h0000_0100);
    chk("ovr_const1", wr_d_q[wr_d_q.size() - 1], 32'h0000_0200);

    // Accumulate onto preloaded value.
    coh_mem[20] = 32'h0010_0010; noncoh_mem[60] = 32'h0000_0050;
    run_req("acc", 10'd20, 10'd60, 5'd1, 1'b0, 0, 0);
    chk("acc_const", wr_d_q[wr_d_q.size() - 1], 32'h0000_0052);

    // Saturating accumulate.
    coh_mem[30] = 32'h7FFF_7FFF; noncoh_mem[70] = 32'hFFFF_FFF0;
    run_req("sat", 10'd30, 10'd70, 5'd1, 1'b0, 0, 0);
    chk("sat_const", wr_d_q[wr_d_q.size() - 1], 32'hFFFF_FFFF);

    // Coherent stage busy between entries.
    coh_mem[40] = 32'h0123_FF00; coh_mem[41] = 32'h8000_0001; coh_mem[42] = 32'h0FFF_F001;
    run_req("stall", 10'd40, 10'd80, 5'd3, 1'b1, 1, 0);
    chk("stall_no_cohrd", 32'(stall_viol), 32'd0);

    run_req("zero", 10'd5, 10'd6, 5'd0, 1'b1, 0, 0);
    coh_mem[100] = 32'h0040_0020; coh_mem[101] = 32'hFFC0_0030;
    noncoh_mem[1023] = 32'h11; noncoh_mem[0] = 32'h22;
    run_req("wrap", 10'd100, 10'd1023, 5'd2, 1'b0, 0, 0);
    run_req("dup", 10'd100, 10'd300, 5'd2, 1'b1, 0, 1);
    for (int i = 0; i < 16; i++) coh_mem[200 + i] = $urandom;
    run_req("clamp", 10'd200, 10'd400, 5'd20, 1'b1, 0, 0);

`ifdef NONCOH_PEAK_EN
    coh_mem[500] = 32'h0020_0000; coh_mem[501] = 32'h0030_0000;
    coh_mem[502] = 32'h0030_0000; coh_mem[503] = 32'h0010_0010;
    run_req("peak", 10'd500, 10'd600, 5'd4, 1'b1, 0, 0);
    chk("peak_const_pw", bus_if.peak_power, 32'd9);
    chk("peak_const_ix", 32'(bus_if.peak_index), 32'd1);
`endif

    // Reset while in ACCUM aborts the request.
    coh_mem[700] = 32'h1000_1000; noncoh_mem[800] = 32'h5;
    bus_if.coh_base_addr = 10'd700; bus_if.noncoh_base_addr = 10'd800;
    bus_if.cor_count = 5'd1; bus_if.first_noncoh = 1'b0; bus_if.noncoh_req = 1'b1;
    for (cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) bus_if.noncoh_req = 1'b0;
    end
    chk("rstm_busy_before", 32'(bus_if.busy), 32'd1);
    wbx = wr_a_q.size(); donex = done_cnt;
    rst_b = 1'b0;
    #1;
    chk("rstm_busy", 32'(bus_if.busy), 32'd0);
    chk("rstm_strobes", {29'd0, bus_if.coh_rd, bus_if.noncoh_rd, bus_if.noncoh_wr}, 32'd0);
    chk("rstm_addr", {12'd0, bus_if.coh_addr, bus_if.noncoh_addr}, 32'd0);
    chk("rstm_d4wt", bus_if.noncoh_d4wt, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("rstm_no_write", 32'(wr_a_q.size() - wbx), 32'd0);
    chk("rstm_no_done", 32'(done_cnt - donex), 32'd0);
    rst_b = 1'b1;
    @(posedge clk); #1;

    // Randomized requests.
    for (int k = 0; k < 25; k++) begin
      rcb = 10'($urandom); rnb = 10'($urandom);
      rcnt = 5'($urandom_range(0, 20)); rfirst = 1'($urandom);
      for (int i = 0; i < 16; i++) begin
        coh_mem[10'(rcb + 10'(i))]    = ($urandom_range(0, 7) == 0) ? 32'h8000_8000 : $urandom;
        noncoh_mem[10'(rnb + 10'(i))] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 + 32'($urandom_range(0, 255)) : $urandom;
      end
      run_req($sformatf("rnd%0d", k), rcb, rnb, rcnt, rfirst, 0, 0);
    end

    chk("strobe_exclusive", 32'(excl_viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
